buffered_fanout_tree: RTL
=========================

// Module: buffered_fanout_tree
// PURPOSE
//   Broadcasts one valid/ready input stream to NUM_LOADS independent load channels.
//   Each channel has its own DEPTH-entry FIFO, so a slow load cannot stall the others
//   until its FIFO is full.
//   Sits between a single high-fanout driver and its loads. It replaces a fixed buffer
//   insertion with an elastic, parametrised buffering stage.
// PARAMETERS
//   WIDTH      8  data bits per beat (>=1)
//   NUM_LOADS  3  number of load channels (>=1)
//   DEPTH      4  entries per channel FIFO (power of 2, >=2)
//   LW         $clog2(DEPTH+1)  level field width (derived, localparam)
// PORTS
//   clk        in   1             single clock, all state on rising edge
//   rst_n      in   1             asynchronous, active-low reset
//   in_valid   in   1             input beat offered
//   in_ready   out  1             input beat accepted when in_valid&&in_ready
//   in_data    in   WIDTH         input beat payload
//   out_valid  out  NUM_LOADS     per-channel beat available
//   out_ready  in   NUM_LOADS     per-channel beat consumed when out_valid[i]&&out_ready[i]
//   out_data   out  NUM_LOADS*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   ch_level   out  NUM_LOADS*LW  channel i occupancy 0..DEPTH, at [i*LW +: LW]
// BEHAVIOUR
//   - Reset (rst_n low, async assert, sync-to-clk release by upstream): all rd/wr ptrs
//     and levels=0; out_valid=0; out_data=0; ch_level=0; in_ready forced 0 while rst_n=0.
//   - in_ready = rst_n && (every channel level < DEPTH). Combinational; does not
//     depend on in_valid. Input is never accepted into a subset of channels.
//   - Accept: the beat is written to all NUM_LOADS FIFOs on the same edge; each level +1.
//   - Latency: a beat accepted at edge k is visible at out_valid/out_data after edge k
//     (i.e. next cycle) when its channel was empty. No combinational in->out path.
//   - Pop on channel i: rd_ptr advances, level -1. Channels pop independently.
//   - Simultaneous push+pop on a channel: level unchanged, both ptrs advance.
//   - Full channel: in_ready=0 even if that channel pops this cycle (no pass-through);
//     in_ready rises the cycle after the pop.
//   - Empty channel: out_valid[i]=0 and out_data slice forced to 0.
//   - Pointers are log2(DEPTH) bits wrapping modulo DEPTH; level is a separate LW-bit counter.
//   - out_data[i] = mem_i[rd_ptr_i] (read from storage; mem itself not reset).
//   - Data ordering per channel is strict FIFO. Every channel sees identical beat sequence.
//   - Reset mid-operation: all FIFOs discard contents immediately; held beats are lost.
//   - Illegal: out_ready with out_valid=0 is ignored (no underflow); in_valid&&!in_ready holds.
// CONFIGURATION
//   BUFFERED_FANOUT_TREE_STATS_EN defined:
//     - Adds output stall_cnt [NUM_LOADS*16].
//     - Channel i counts cycles with out_valid[i]&&!out_ready[i].
//     - Adds output block_cnt [16] counting cycles with in_valid&&!in_ready.
//     - All counters saturate at 16'hFFFF. They reset to 0 on rst_n.
//   Not defined: these ports and counters do not exist; datapath behaviour is identical.
// TESTING
//   1 Reset: rst_n=0 mid-stream with 2 beats queued -> out_valid=0, ch_level=0,
//     in_ready=0. Release rst_n -> in_ready=1 next cycle.
//   2 Broadcast: NUM_LOADS=3, all out_ready=1, send 8'hA5,8'h3C -> each channel outputs
//     A5 then 3C, one cycle after acceptance, ch_level peaks at 1.
//   3 Back-pressure: hold out_ready[1]=0, others 1, send 5 beats, DEPTH=4 -> 4 accepted,
//     in_ready=0 on 5th, ch_level[1]=4, ch_level[0]=ch_level[2]=0.
//     Release out_ready[1] -> in_ready=1 one cycle after first pop.
//   4 Push+pop when level=2 on all channels -> levels stay 2, order preserved.
//   5 Wrap: stream 3*DEPTH+1 incrementing beats with random out_ready -> per-channel
//     output = 0..12 in order, no loss/duplication.
//   6 STATS_EN: stall ch0 for 10 cycles with out_valid=1 -> stall_cnt[0]=10.
//     Force 70000 stall cycles -> saturates at FFFF.

Source files
------------

// File: rtl/buffered_fanout_tree.sv
// Broadcasts one valid/ready stream to NUM_LOADS channels, each with its own DEPTH-entry FIFO.
// Optional per-channel stall and input block counters: define BUFFERED_FANOUT_TREE_STATS_EN.
module buffered_fanout_tree #(
  parameter int WIDTH     = 8,
  parameter int NUM_LOADS = 3,
  parameter int DEPTH     = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [WIDTH-1:0]                         in_data,
  output logic [NUM_LOADS-1:0]                     out_valid,
  input  logic [NUM_LOADS-1:0]                     out_ready,
  output logic [NUM_LOADS*WIDTH-1:0]               out_data,
  output logic [NUM_LOADS*$clog2(DEPTH+1)-1:0]     ch_level
`ifdef BUFFERED_FANOUT_TREE_STATS_EN
  ,
  output logic [NUM_LOADS*16-1:0]                  stall_cnt,
  output logic [15:0]                              block_cnt
`endif
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [NUM_LOADS-1:0] full;
  logic                 push;

  // A beat is only taken when every channel has room, so all channels see the same sequence.
  assign in_ready = rst_n && !(|full);
  assign push     = in_valid && in_ready;

  for (genvar g = 0; g < NUM_LOADS; g++) begin : g_ch
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             pop;

    assign pop = out_ready[g] && (level_q != '0);

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
      end
    end

    // Storage carries no reset; the level counter alone decides what is valid.
    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
    end

    assign full[g]                      = (level_q == FULL_LVL);
    assign out_valid[g]                 = (level_q != '0);
    assign out_data[g*WIDTH +: WIDTH]   = out_valid[g] ? mem_q[rd_ptr_q] : '0;
    assign ch_level[g*LW +: LW]         = level_q;

`ifdef BUFFERED_FANOUT_TREE_STATS_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
      stall_d = stall_q;
      if (out_valid[g] && !out_ready[g] && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_q <= '0;
      else        stall_q <= stall_d;
    end

    assign stall_cnt[g*16 +: 16] = stall_q;
`endif
  end

`ifdef BUFFERED_FANOUT_TREE_STATS_EN
  logic [15:0] block_q, block_d;

  always_comb begin
    block_d = block_q;
    if (in_valid && !in_ready && (block_q != 16'hFFFF)) block_d = block_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) block_q <= '0;
    else        block_q <= block_d;
  end

  assign block_cnt = block_q;
`endif

endmodule
